// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, icache request issue,
// in-order response pairing into a {pc, inst} queue, and redirect flush/restart.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  input  logic        fetch_ready
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = PTR_W + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  logic [XLEN-1:0]   next_pc_q, next_pc_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              stale_q, stale_d;
  logic              req_hold_q, req_hold_d;
  logic [CNT_W-1:0]  live_q, live_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0]  pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
  logic [PTR_W-1:0]  q_wr_q, q_wr_d, q_rd_q, q_rd_d;

  logic [XLEN-1:0]   pcf_mem [DEPTH];
  fetch_entry_t      q_mem   [DEPTH];

  logic credit_c;
  logic req_fire_c;
  logic resp_fire_c;
  logic drop_pend_c;
  logic live_push_c;
  logic live_resp_c;
  logic q_push_c;
  logic pop_c;
  logic hold_next_c;

  // Handshake and credit decode
  always_comb begin
    credit_c       = ((CNT_W+1)'(occ_q) + (CNT_W+1)'(live_q)) < (CNT_W+1)'(DEPTH);
    Inst_Req_Valid = cpu_resetn & (req_hold_q | credit_c);
    PC             = next_pc_q;
    req_fire_c     = Inst_Req_Valid & Inst_Req_Ready;
    hold_next_c    = Inst_Req_Valid & ~Inst_Req_Ready;
    drop_pend_c    = (drop_q != '0);
    Inst_Ready     = drop_pend_c | (occ_q < CNT_W'(DEPTH));
    resp_fire_c    = Inst_Valid & Inst_Ready;
    live_push_c    = req_fire_c & ~stale_q;
    live_resp_c    = resp_fire_c & ~drop_pend_c;
    q_push_c       = live_resp_c & ~redirect_valid;
    fetch_valid    = (occ_q != '0) & ~redirect_valid;
    pop_c          = fetch_valid & fetch_ready;
    fetch_pc       = q_mem[q_rd_q].pc;
    fetch_inst     = q_mem[q_rd_q].inst;
  end

  // Next-state for counters, pointers and the request stream
  always_comb begin
    next_pc_d  = next_pc_q;
    redir_pc_d = redir_pc_q;
    stale_d    = stale_q;
    req_hold_d = hold_next_c;
    pcf_wr_d   = pcf_wr_q;
    pcf_rd_d   = pcf_rd_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;

    if (req_fire_c) begin
      if (stale_q) begin
        next_pc_d = redir_pc_q;
        stale_d   = 1'b0;
      end else begin
        next_pc_d = next_pc_q + 32'd4;
        pcf_wr_d  = pcf_wr_q + PTR_W'(1);
      end
    end
    if (live_resp_c) pcf_rd_d = pcf_rd_q + PTR_W'(1);
    if (q_push_c)    q_wr_d   = q_wr_q + PTR_W'(1);
    if (pop_c)       q_rd_d   = q_rd_q + PTR_W'(1);

    live_d = live_q + CNT_W'(live_push_c) - CNT_W'(live_resp_c);
    occ_d  = occ_q + CNT_W'(q_push_c) - CNT_W'(pop_c);
    drop_d = drop_q + DROP_W'(req_fire_c & stale_q)
                    - DROP_W'(resp_fire_c & drop_pend_c);

    // Flush: everything live or accepted this cycle becomes a response to drop
    if (redirect_valid) begin
      occ_d    = '0;
      live_d   = '0;
      pcf_wr_d = '0;
      pcf_rd_d = '0;
      q_wr_d   = '0;
      q_rd_d   = '0;
      drop_d   = drop_q + DROP_W'(live_q) + DROP_W'(req_fire_c)
                        - DROP_W'(resp_fire_c);
      if (hold_next_c) begin
        stale_d    = 1'b1;
        redir_pc_d = redirect_pc;
      end else begin
        next_pc_d = redirect_pc;
        stale_d   = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      next_pc_q  <= RESET_PC;
      redir_pc_q <= '0;
      stale_q    <= 1'b0;
      req_hold_q <= 1'b0;
      live_q     <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
    end else begin
      next_pc_q  <= next_pc_d;
      redir_pc_q <= redir_pc_d;
      stale_q    <= stale_d;
      req_hold_q <= req_hold_d;
      live_q     <= live_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      pcf_wr_q   <= pcf_wr_d;
      pcf_rd_q   <= pcf_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
    end
  end

  // Storage arrays; validity is tracked by the counters above
  always_ff @(posedge cpu_clk) begin
    if (live_push_c) pcf_mem[pcf_wr_q] <= next_pc_q;
    if (q_push_c)    q_mem[q_wr_q]     <= '{pc: pcf_mem[pcf_rd_q], inst: Instruction};
  end

endmodule
